pipe_stall_ctrl: RTL and testbench

//  Central hazard/stall controller for the 5-stage pipeline: IF, ID, EX, MEM, WB.

---
 rtl/pipe_stall_ctrl_pkg.sv | 29 ++
 rtl/pipe_stall_ctrl_if.sv | 39 +++
 rtl/pipe_stall_ctrl_wait_cnt.sv | 26 ++
 rtl/pipe_stall_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
//   state_t : controller FSM encoding (S_RUN = 0, S_MEM = 1)
//   ctl_t   : per-stage hold/bubble bundle driven to the pipeline registers
//   REG_AW  : default register address width
package pipe_stall_ctrl_pkg;

  typedef enum logic {S_RUN = 1'b0, S_MEM = 1'b1} state_t;

  localparam int REG_AW = 4;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_wb;
  } ctl_t;

  localparam ctl_t CTL_NONE = 7'b0000_000;
  // Whole pipe held; the instruction leaving MEM is replaced by a bubble.
  localparam ctl_t CTL_FULL = 7'b1111_001;
  // PC held while the rest advances; a bubble enters IF/ID.
  localparam ctl_t CTL_LAST = 7'b1000_100;
  localparam ctl_t CTL_LU   = 7'b1100_010;
  localparam ctl_t CTL_BR   = 7'b0000_100;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/flush outputs between the pipeline and the
// stall controller.
//   master : pipeline side (drives hazard sources, receives holds/bubbles)
//   slave  : controller side
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int RW = REG_AW
) ();

  logic          mem_op;
  logic          ext_hold;
  logic          ex_load;
  logic [RW-1:0] ex_rd;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_rs_use;
  logic          id_rt_use;
  logic          branch_taken;
  logic          stall_if;
  logic          stall_id;
  logic          stall_ex;
  logic          stall_mem;
  logic          flush_id;
  logic          flush_ex;
  logic          flush_wb;
  logic          busy;

  modport master (
    output mem_op, ext_hold, ex_load, ex_rd, id_rs, id_rt, id_rs_use, id_rt_use, branch_taken,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, busy
  );

  modport slave (
    input  mem_op, ext_hold, ex_load, ex_rd, id_rs, id_rt, id_rs_use, id_rt_use, branch_taken,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, busy
  );

endinterface

// File: rtl/pipe_stall_ctrl_wait_cnt.sv
// stall_wait_cnt: loadable down-counter timing the shared-bus wait.
//   clk, rst   : clock, async active-low reset (cnt -> 0)
//   load       : load load_val (has priority over en)
//   en         : decrement by one
//   cnt, zero  : current count and cnt==0 flag
module stall_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard/stall controller for the IF-ID-EX-MEM-WB pipeline.
// Priority ext_hold > shared-bus wait > load-use > taken branch; only the
// winning rule drives the hold/bubble outputs, which are combinational and
// forced to 0 while rst is low.
//   clk, rst : clock, async active-low reset
//   bus      : pipe_stall_ctrl_if.slave (hazard inputs, stall/flush/busy)
//   perf_*   : saturating won-cycle counters, only with STALL_PERF_EN defined
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int RW       = REG_AW,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_mem,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_br
`endif
);

  localparam int CW = $clog2(MEM_WAIT) + 1;
  // First S_RUN cycle counts as one wait cycle and the cnt==0 cycle as the last.
  localparam logic [CW-1:0] LOAD_VAL = CW'((MEM_WAIT > 1) ? MEM_WAIT - 2 : 0);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          cnt_zero, cnt_load, cnt_en;
  logic [RW-1:0] ex_rd;
  logic          hazard, mem_win, lu_win, br_win;
  ctl_t          ctl, ctl_out;

  assign ex_rd  = bus.ex_rd;
  assign hazard = bus.ex_load && (ex_rd != '0) &&
                  ((bus.id_rs_use && bus.id_rs == ex_rd) ||
                   (bus.id_rt_use && bus.id_rt == ex_rd));

  stall_wait_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nx;
  end

  // ext_hold leaves state_nx/cnt controls at their defaults, freezing the wait.
  always_comb begin
    ctl      = CTL_NONE;
    state_nx = state;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    mem_win  = 1'b0;
    lu_win   = 1'b0;
    br_win   = 1'b0;
    if (bus.ext_hold) begin
      ctl = CTL_FULL;
    end else if (MEM_WAIT == 1 && bus.mem_op) begin
      ctl     = CTL_LAST;
      mem_win = 1'b1;
    end else if (MEM_WAIT > 1 && state == S_MEM) begin
      // mem_op is not sampled here; the held pipe keeps it asserted.
      mem_win = 1'b1;
      if (!cnt_zero) begin
        ctl    = CTL_FULL;
        cnt_en = 1'b1;
      end else begin
        ctl      = CTL_LAST;
        state_nx = S_RUN;
      end
    end else if (MEM_WAIT > 1 && bus.mem_op) begin
      ctl      = CTL_FULL;
      cnt_load = 1'b1;
      state_nx = S_MEM;
      mem_win  = 1'b1;
    end else if (hazard) begin
      ctl    = CTL_LU;
      lu_win = 1'b1;
    end else if (bus.branch_taken) begin
      ctl    = CTL_BR;
      br_win = 1'b1;
    end
  end

  assign ctl_out       = rst ? ctl : CTL_NONE;
  assign bus.stall_if  = ctl_out.stall_if;
  assign bus.stall_id  = ctl_out.stall_id;
  assign bus.stall_ex  = ctl_out.stall_ex;
  assign bus.stall_mem = ctl_out.stall_mem;
  assign bus.flush_id  = ctl_out.flush_id;
  assign bus.flush_ex  = ctl_out.flush_ex;
  assign bus.flush_wb  = ctl_out.flush_wb;
  assign bus.busy      = rst && (state == S_MEM);

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mem <= '0;
      perf_lu  <= '0;
      perf_br  <= '0;
    end else begin
      if (mem_win && !(&perf_mem)) perf_mem <= perf_mem + 1'b1;
      if (lu_win  && !(&perf_lu))  perf_lu  <= perf_lu  + 1'b1;
      if (br_win  && !(&perf_br))  perf_br  <= perf_br  + 1'b1;
    end
  end
`else
  logic unused_win;
  assign unused_win = mem_win ^ lu_win ^ br_win;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: dut_a (MEM_WAIT=1) and dut_b (MEM_WAIT=3) share
// one stimulus stream. Observed word = {stall_if,id,ex,mem, flush_id,ex,wb, busy}.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic       mem_op, ext_hold, ex_load;
    logic [3:0] ex_rd, id_rs, id_rt;
    logic       id_rs_use, id_rt_use, branch_taken;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] ea, eb;
    string      tag;
  } vec_t;

  typedef struct {
    string      tag;
    logic [7:0] ea, eb;
  } exp_t;

  localparam logic [7:0] Z      = 8'b0000_0000;
  localparam logic [7:0] FULL   = 8'b1111_0010;
  localparam logic [7:0] FULL_B = 8'b1111_0011;
  localparam logic [7:0] LAST   = 8'b1000_1000;
  localparam logic [7:0] LAST_B = 8'b1000_1001;
  localparam logic [7:0] LU     = 8'b1100_0100;
  localparam logic [7:0] BR     = 8'b0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  cur = '0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.RW(4)) ifa ();
  pipe_stall_ctrl_if #(.RW(4)) ifb ();

  assign ifa.mem_op = cur.mem_op;       assign ifb.mem_op = cur.mem_op;
  assign ifa.ext_hold = cur.ext_hold;   assign ifb.ext_hold = cur.ext_hold;
  assign ifa.ex_load = cur.ex_load;     assign ifb.ex_load = cur.ex_load;
  assign ifa.ex_rd = cur.ex_rd;         assign ifb.ex_rd = cur.ex_rd;
  assign ifa.id_rs = cur.id_rs;         assign ifb.id_rs = cur.id_rs;
  assign ifa.id_rt = cur.id_rt;         assign ifb.id_rt = cur.id_rt;
  assign ifa.id_rs_use = cur.id_rs_use; assign ifb.id_rs_use = cur.id_rs_use;
  assign ifa.id_rt_use = cur.id_rt_use; assign ifb.id_rt_use = cur.id_rt_use;
  assign ifa.branch_taken = cur.branch_taken;
  assign ifb.branch_taken = cur.branch_taken;

`ifdef STALL_PERF_EN
  logic [15:0] pm_a, pl_a, pb_a, pm_b, pl_b, pb_b;
`endif

  pipe_stall_ctrl #(.MEM_WAIT(1), .RW(4), .PERF_W(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
`ifdef STALL_PERF_EN
    , .perf_mem (pm_a), .perf_lu (pl_a), .perf_br (pb_a)
`endif
  );

  pipe_stall_ctrl #(.MEM_WAIT(3), .RW(4), .PERF_W(16)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
`ifdef STALL_PERF_EN
    , .perf_mem (pm_b), .perf_lu (pl_b), .perf_br (pb_b)
`endif
  );

  wire [7:0] out_a = {ifa.stall_if, ifa.stall_id, ifa.stall_ex, ifa.stall_mem,
                      ifa.flush_id, ifa.flush_ex, ifa.flush_wb, ifa.busy};
  wire [7:0] out_b = {ifb.stall_if, ifb.stall_id, ifb.stall_ex, ifb.stall_mem,
                      ifb.flush_id, ifb.flush_ex, ifb.flush_wb, ifb.busy};

  function automatic in_t mk(logic mo, logic eh, logic ld, logic [3:0] rd,
                             logic [3:0] rs, logic [3:0] rt, logic rsu,
                             logic rtu, logic br);
    in_t v;
    v = '{mo, eh, ld, rd, rs, rt, rsu, rtu, br};
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(in_t v, string tag, logic [7:0] ea, logic [7:0] eb);
    exp_t e;
    cur = v;
    sb.push_back('{tag, ea, eb});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_a"}, {8'h00, out_a}, {8'h00, e.ea});
      chk({e.tag, "_b"}, {8'h00, out_b}, {8'h00, e.eb});
    end
    @(posedge clk);
    #1;
  endtask

  in_t idle, lu_in, mem1;

  initial begin
    idle  = '0;
    lu_in = mk(0, 0, 1, 4'd3, 4'd0, 4'd3, 0, 1, 0);
    mem1  = mk(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);

    tbl[0]  = '{idle,                                   Z,    Z,    "idle"};
    tbl[1]  = '{lu_in,                                  LU,   LU,   "lu_rt"};
    tbl[2]  = '{mk(0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1, 0), Z,    Z,    "lu_rd0"};
    tbl[3]  = '{mk(0, 0, 1, 4'd3, 4'd0, 4'd3, 0, 0, 0), Z,    Z,    "lu_rtuse0"};
    tbl[4]  = '{mk(0, 0, 1, 4'd5, 4'd5, 4'd1, 1, 1, 0), LU,   LU,   "lu_rs"};
    tbl[5]  = '{mk(0, 0, 1, 4'd5, 4'd5, 4'd1, 0, 1, 0), Z,    Z,    "lu_rsuse0"};
    tbl[6]  = '{mk(0, 0, 0, 4'd3, 4'd3, 4'd3, 1, 1, 0), Z,    Z,    "no_load"};
    tbl[7]  = '{mk(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1), BR,   BR,   "branch"};
    tbl[8]  = '{mk(0, 0, 1, 4'd3, 4'd0, 4'd3, 0, 1, 1), LU,   LU,   "lu_over_br"};
    tbl[9]  = '{mk(0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0), FULL, FULL, "ext"};
    tbl[10] = '{mk(0, 1, 1, 4'd3, 4'd0, 4'd3, 0, 1, 1), FULL, FULL, "ext_over_all"};

    // Outputs gated while in reset, even with active hazard inputs.
    step(mk(1, 1, 1, 4'd3, 4'd0, 4'd3, 0, 1, 1), "in_reset", Z, Z);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) step(tbl[i].in, tbl[i].tag, tbl[i].ea, tbl[i].eb);

    // mem_op held: MEM_WAIT=3 runs its 3-cycle wait then re-enters.
    step(mem1,  "held0",  LAST, FULL);
    step(mem1,  "held1",  LAST, FULL_B);
    step(mem1,  "held2",  LAST, LAST_B);
    step(mem1,  "reent0", LAST, FULL);
    step(lu_in, "reent1", LU,   FULL_B);
    step(lu_in, "reent2", LU,   LAST_B);
    step(idle,  "reent3", Z,    Z);

    // Single-cycle mem_op; S_MEM completes without it.
    step(mem1, "pulse0", LAST, FULL);
    step(idle, "pulse1", Z,    FULL_B);
    step(idle, "pulse2", Z,    LAST_B);
    step(idle, "pulse3", Z,    Z);

    // Async reset while dut_b waits with cnt=1.
    step(mem1, "rst_pre", LAST, FULL);
    rst = 1'b0;
    step(mk(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1), "rst_mid", Z, Z);
    rst = 1'b1;
    step(idle, "rst_post", Z, Z);
    step(mk(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1), "rst_br", BR, BR);
    step(idle, "rst_idle", Z, Z);

    // ext_hold freezes S_MEM with cnt=1; the wait then finishes normally.
    step(mem1, "frz_pre", LAST, FULL);
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0), "frz", FULL, FULL_B);
`ifdef STALL_PERF_EN
    chk("perf_mem_b_frz", pm_b, 16'd1);
    chk("perf_mem_a_frz", pm_a, 16'd1);
    chk("perf_br_a", pb_a, 16'd1);
`endif
    step(idle, "frz_post1", Z, FULL_B);
    step(idle, "frz_post2", Z, LAST_B);
    step(idle, "frz_post3", Z, Z);
`ifdef STALL_PERF_EN
    chk("perf_mem_b_end", pm_b, 16'd3);
    chk("perf_mem_a_end", pm_a, 16'd1);
    chk("perf_lu_b", pl_b, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
